// File: rtl/usb_bus_master.sv
// ============================================================================
// Module      : usb_bus_master
// Description : Initiator for the 8-bit multiplexed-address parallel register
//               bus; turns (addr, dir, len) commands into timed bus cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_bus_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic [7:0]  usb_addr,
    output logic [7:0]  usb_d_out,
    output logic        usb_d_oe,
    input  logic [7:0]  usb_d_in,
    output logic        usb_alen,
    output logic        usb_rdn,
    output logic        usb_wrn,
    output logic        usb_cen
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ALE      = 3'd1,
        S_ALE_HOLD = 3'd2,
        S_FETCH    = 3'd3,
        S_SETUP    = 3'd4,
        S_STROBE   = 3'd5,
        S_HOLD     = 3'd6,
        S_END      = 3'd7
    } state_t;

    // Phase counters are loaded with (length - 1) and count down to zero.
    localparam logic [3:0] c_setup_last  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] c_strobe_last = 4'(STROBE_CYC - 1);
    localparam logic [3:0] c_hold_last   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rem_q, rem_d;
    logic        write_q, write_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        wr_ready_q, wr_ready_d;
    logic        alen_q, alen_d;
    logic        rdn_q, rdn_d;
    logic        wrn_q, wrn_d;
    logic        cen_q, cen_d;
    logic        oe_q, oe_d;

    logic        cnt_last;
    logic        cmd_fire;
    logic        wr_fire;

    assign cnt_last = (cnt_q == 4'd0);
    assign cmd_fire = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
    assign wr_fire  = (state_q == S_FETCH) && wr_valid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_last ? cnt_q : (cnt_q - 4'd1);
        rem_d      = rem_q;
        write_d    = write_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    cnt_d   = c_strobe_last;
                    state_d = (cmd_len == 16'd0) ? S_END : S_ALE;
                end
            end
            S_ALE: begin
                if (cnt_last) begin
                    cnt_d   = c_hold_last;
                    state_d = S_ALE_HOLD;
                end
            end
            S_ALE_HOLD: begin
                if (cnt_last) begin
                    cnt_d   = c_setup_last;
                    state_d = write_q ? S_FETCH : S_SETUP;
                end
            end
            S_FETCH: begin
                if (wr_fire) begin
                    dout_d  = wr_data;
                    cnt_d   = c_setup_last;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_last) begin
                    cnt_d   = c_strobe_last;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (cnt_last) begin
                    // Read data is captured on the edge that releases usb_rdn.
                    if (!write_q) begin
                        rdata_d    = usb_d_in;
                        rd_valid_d = 1'b1;
                    end
                    cnt_d   = c_hold_last;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_last) begin
                    rem_d = rem_q - 16'd1;
                    cnt_d = c_setup_last;
                    if (rem_q == 16'd1) begin
                        state_d = S_END;
                    end else begin
                        state_d = write_q ? S_FETCH : S_SETUP;
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus strobes and handshakes are registered, decoded from the next state.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        wr_ready_d  = (state_d == S_FETCH);
        done_d      = (state_d == S_END);
        alen_d      = (state_d != S_ALE);
        cen_d       = (state_d == S_IDLE) || (state_d == S_END);
        rdn_d       = !((state_d == S_STROBE) && !write_d);
        wrn_d       = !((state_d == S_STROBE) && write_d);
        oe_d        = write_d && ((state_d == S_SETUP) ||
                                  (state_d == S_STROBE) ||
                                  (state_d == S_HOLD));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rem_q       <= 16'd0;
            write_q     <= 1'b0;
            addr_q      <= 8'd0;
            dout_q      <= 8'd0;
            rdata_q     <= 8'd0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            alen_q      <= 1'b1;
            rdn_q       <= 1'b1;
            wrn_q       <= 1'b1;
            cen_q       <= 1'b1;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            rdata_q     <= rdata_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            alen_q      <= alen_d;
            rdn_q       <= rdn_d;
            wrn_q       <= wrn_d;
            cen_q       <= cen_d;
            oe_q        <= oe_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_data   = rdata_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign usb_addr  = addr_q;
    assign usb_d_out = dout_q;
    assign usb_d_oe  = oe_q;
    assign usb_alen  = alen_q;
    assign usb_rdn   = rdn_q;
    assign usb_wrn   = wrn_q;
    assign usb_cen   = cen_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_bus_master.sv
// ============================================================================
// Module      : tb_usb_bus_master
// Description : Directed self-checking bench for usb_bus_master (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_bus_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_len;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [7:0]  usb_addr;
    logic [7:0]  usb_d_out;
    logic        usb_d_oe;
    logic [7:0]  usb_d_in;
    logic        usb_alen;
    logic        usb_rdn;
    logic        usb_wrn;
    logic        usb_cen;

    int n_run  = 0;
    int n_fail = 0;
    logic [7:0] resp [0:3];

    always #5 clk = ~clk;

    usb_bus_master #(
        .SETUP_CYC (2),
        .STROBE_CYC(4),
        .HOLD_CYC  (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .usb_addr (usb_addr),
        .usb_d_out(usb_d_out),
        .usb_d_oe (usb_d_oe),
        .usb_d_in (usb_d_in),
        .usb_alen (usb_alen),
        .usb_rdn  (usb_rdn),
        .usb_wrn  (usb_wrn),
        .usb_cen  (usb_cen)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Leaves the bench at a negedge where cmd_ready is high (cycle 0 of a command).
    task automatic wait_ready();
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    // Read burst of n bytes; responder drives resp[i] only inside strobe windows.
    task automatic run_read(input logic [7:0] a, input int n);
        logic in_s;
        logic rv;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = a;
        cmd_len   = 16'(n);
        for (int t = 1; t <= 8 * n + 8; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            in_s = (t >= 9) && (((t - 9) % 8) < 4) && (((t - 9) / 8) < n);
            usb_d_in = in_s ? resp[(t - 9) / 8] : 8'hEE;
            rv = (t >= 13) && (((t - 13) % 8) == 0) && (((t - 13) / 8) < n);
            chk("rd_rdn", 32'(usb_rdn), 32'(!in_s));
            chk("rd_wrn", 32'(usb_wrn), 32'd1);
            chk("rd_oe", 32'(usb_d_oe), 32'd0);
            chk("rd_alen", 32'(usb_alen), 32'(!(t <= 4)));
            chk("rd_valid", 32'(rd_valid), 32'(rv));
            if (rv) chk("rd_data", 32'(rd_data), 32'(resp[(t - 13) / 8]));
            chk("rd_done", 32'(done), 32'(t == 8 * n + 7));
            chk("rd_cen", 32'(usb_cen), 32'(t >= 8 * n + 7));
            chk("rd_ready", 32'(cmd_ready), 32'(t == 8 * n + 8));
            if (t <= 8 * n + 7) chk("rd_addr", 32'(usb_addr), 32'(a));
        end
        usb_d_in = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_len   = 16'd0;
        wr_data   = 8'h00;
        wr_valid  = 1'b0;
        usb_d_in  = 8'h00;
        resp[0] = 8'h11;
        resp[1] = 8'h22;
        resp[2] = 8'h33;
        resp[3] = 8'h44;

        repeat (3) @(negedge clk);
        chk("rst_cen", 32'(usb_cen), 32'd1);
        chk("rst_alen", 32'(usb_alen), 32'd1);
        chk("rst_rdn", 32'(usb_rdn), 32'd1);
        chk("rst_wrn", 32'(usb_wrn), 32'd1);
        chk("rst_oe", 32'(usb_d_oe), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(usb_addr), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", 32'(cmd_ready), 32'd1);

        // Single-byte write, addr 0x2A, data 0x5C offered from cycle 0.
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h2A;
        cmd_len   = 16'd1;
        wr_data   = 8'h5C;
        wr_valid  = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (t >= 8) wr_valid = 1'b0;
            chk("w1_alen", 32'(usb_alen), 32'(!(t <= 4)));
            chk("w1_cen", 32'(usb_cen), 32'(t >= 16));
            chk("w1_wr_ready", 32'(wr_ready), 32'(t == 7));
            chk("w1_oe", 32'(usb_d_oe), 32'(t >= 8 && t <= 15));
            if (t >= 8 && t <= 15) chk("w1_dout", 32'(usb_d_out), 32'h5C);
            chk("w1_wrn", 32'(usb_wrn), 32'(!(t >= 10 && t <= 13)));
            chk("w1_rdn", 32'(usb_rdn), 32'd1);
            chk("w1_done", 32'(done), 32'(t == 16));
            chk("w1_busy", 32'(busy), 32'(t <= 16));
            chk("w1_ready", 32'(cmd_ready), 32'(t == 17));
            if (t <= 16) chk("w1_addr", 32'(usb_addr), 32'h2A);
        end

        // Three-byte read, addr 0x03.
        run_read(8'h03, 3);

        // Two-byte write with second byte withheld for 10 FETCH cycles.
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h41;
        cmd_len   = 16'd2;
        wr_data   = 8'hA5;
        wr_valid  = 1'b1;
        for (int t = 1; t <= 36; t++) begin
            logic fetch, stb, oe_win;
            @(negedge clk);
            cmd_valid = 1'b0;
            wr_valid  = (t <= 7) || (t == 26);
            wr_data   = (t <= 7) ? 8'hA5 : ((t == 26) ? 8'h3C : 8'hFF);
            fetch  = (t == 7) || (t >= 16 && t <= 26);
            stb    = (t >= 10 && t <= 13) || (t >= 29 && t <= 32);
            oe_win = (t >= 8 && t <= 15) || (t >= 27 && t <= 34);
            chk("st_wr_ready", 32'(wr_ready), 32'(fetch));
            chk("st_cen", 32'(usb_cen), 32'(t >= 35));
            chk("st_wrn", 32'(usb_wrn), 32'(!stb));
            chk("st_rdn", 32'(usb_rdn), 32'd1);
            chk("st_alen", 32'(usb_alen), 32'(!(t <= 4)));
            chk("st_oe", 32'(usb_d_oe), 32'(oe_win));
            if (stb) chk("st_dout", 32'(usb_d_out), (t < 20) ? 32'hA5 : 32'h3C);
            chk("st_done", 32'(done), 32'(t == 35));
            chk("st_ready", 32'(cmd_ready), 32'(t == 36));
        end
        wr_valid = 1'b0;

        // Zero-length command: done one cycle after accept, no strobes.
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h10;
        cmd_len   = 16'd0;
        for (int t = 1; t <= 2; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("z_done", 32'(done), 32'(t == 1));
            chk("z_cen", 32'(usb_cen), 32'd1);
            chk("z_alen", 32'(usb_alen), 32'd1);
            chk("z_rdn", 32'(usb_rdn), 32'd1);
            chk("z_wrn", 32'(usb_wrn), 32'd1);
            chk("z_busy", 32'(busy), 32'(t == 1));
            chk("z_ready", 32'(cmd_ready), 32'(t == 2));
        end

        // Reset asserted during the 2nd STROBE cycle of a write.
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h44;
        cmd_len   = 16'd4;
        wr_data   = 8'h99;
        wr_valid  = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (t == 10 || t == 11) chk("ab_wrn_low", 32'(usb_wrn), 32'd0);
            if (t == 11) begin
                reset_n  = 1'b0;
                wr_valid = 1'b0;
            end
            if (t == 12) begin
                chk("ab_cen", 32'(usb_cen), 32'd1);
                chk("ab_alen", 32'(usb_alen), 32'd1);
                chk("ab_rdn", 32'(usb_rdn), 32'd1);
                chk("ab_wrn", 32'(usb_wrn), 32'd1);
                chk("ab_oe", 32'(usb_d_oe), 32'd0);
                chk("ab_addr", 32'(usb_addr), 32'd0);
                chk("ab_dout", 32'(usb_d_out), 32'd0);
                chk("ab_rd_data", 32'(rd_data), 32'd0);
                chk("ab_wr_ready", 32'(wr_ready), 32'd0);
                chk("ab_ready", 32'(cmd_ready), 32'd0);
                chk("ab_busy", 32'(busy), 32'd0);
                chk("ab_done", 32'(done), 32'd0);
                reset_n = 1'b1;
            end
            if (t >= 13) begin
                chk("ab_no_done", 32'(done), 32'd0);
                chk("ab_idle_busy", 32'(busy), 32'd0);
                chk("ab_idle_cen", 32'(usb_cen), 32'd1);
                chk("ab_idle_ready", 32'(cmd_ready), 32'd1);
            end
        end
        run_read(8'h55, 1);

        // Back-to-back reads with cmd_valid held high.
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h66;
        cmd_len   = 16'd1;
        usb_d_in  = 8'h77;
        for (int t = 1; t <= 32; t++) begin
            @(negedge clk);
            if (t >= 17) cmd_valid = 1'b0;
            chk("bb_done", 32'(done), 32'(t == 15 || t == 31));
            chk("bb_ready", 32'(cmd_ready), 32'(t == 16 || t == 32));
            chk("bb_cen", 32'(usb_cen), 32'(t == 15 || t == 16 || t >= 31));
            chk("bb_alen", 32'(usb_alen), 32'(!((t <= 4) || (t >= 17 && t <= 20))));
            chk("bb_rdn", 32'(usb_rdn), 32'(!((t >= 9 && t <= 12) || (t >= 25 && t <= 28))));
            chk("bb_rd_valid", 32'(rd_valid), 32'(t == 13 || t == 29));
            if (t == 13 || t == 29) chk("bb_rd_data", 32'(rd_data), 32'h77);
            chk("bb_busy", 32'(busy), 32'(t != 16 && t != 32));
        end
        usb_d_in = 8'h00;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/usb_bus_master.md
# usb_bus_master

Initiator for the 8-bit SAM3U-style parallel register bus (multiplexed address latch, active-low read/write/chip-enable strobes) on which the capture FPGA is the responder. It turns a command stream (address, direction, byte count) into correctly timed bus cycles, with a streaming byte interface on each side. It is used in the bench harness to drive the capture top level, and on hosts where one FPGA drives another FPGA's register bus.

## Interface
Parameters:
- SETUP_CYC, 2, cycles data/direction is stable before a strobe falls (1..15)
- STROBE_CYC, 4, cycles USB_ALEn/RDn/WRn are held low (1..15)
- HOLD_CYC, 2, cycles after a strobe rises before the next phase (1..15)

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; a command transfers when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  8  register address, latched at command transfer
- cmd_len  in  16  byte count; 0 means no bus activity
- wr_data  in  8  write byte
- wr_valid  in  1  write byte offered
- wr_ready  out  1  high in FETCH; a byte transfers when wr_valid && wr_ready
- rd_data  out  8  read byte, valid while rd_valid is high
- rd_valid  out  1  one-cycle pulse per read byte; no backpressure
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at command completion
- usb_addr  out  8  address bus
- usb_d_out  out  8  data bus, driven value
- usb_d_oe  out  1  data bus output enable (1 = master drives)
- usb_d_in  in  8  data bus, sampled value
- usb_alen, usb_rdn, usb_wrn, usb_cen  out  1 each  active-low strobes

## Operation
- States: IDLE, ALE, ALE_HOLD, FETCH, SETUP, STROBE, HOLD, END.
- IDLE: cmd_ready=1 and all strobes high. On transfer, latch addr/write/len and go to ALE. If cmd_len=0, go to END instead.
- ALE (STROBE_CYC cycles): usb_cen=0, usb_alen=0, usb_addr=cmd_addr. Then ALE_HOLD.
- ALE_HOLD (HOLD_CYC cycles): usb_alen=1.
  - Write: go to FETCH.
  - Read: go to SETUP.
- FETCH: wr_ready=1. The block waits indefinitely (usb_cen stays low, other strobes high). On transfer, register wr_data into usb_d_out, then go to SETUP.
- SETUP (SETUP_CYC cycles): usb_d_oe = write.
- STROBE (STROBE_CYC cycles): usb_wrn=0 for a write, usb_rdn=0 for a read. On a read, usb_d_in is registered at the edge that ends the last STROBE cycle.
- HOLD (HOLD_CYC cycles): strobe high. For a write, data and oe are held.
  - On a read, rd_valid=1 and rd_data is valid in the first HOLD cycle.
  - After HOLD: decrement the remaining count. If nonzero, go to FETCH (write) or SETUP (read); otherwise go to END.
- END (1 cycle): usb_cen=1, usb_d_oe=0, done=1. Then IDLE.
- usb_addr is constant for the whole burst; the responder increments its internal byte count itself.
- Strobes are registered outputs. usb_rdn and usb_wrn are never low at the same time. usb_d_oe=0 whenever usb_rdn=0.
- Remaining count is 16-bit unsigned, so cmd_len=65535 is a legal burst. The phase counter is 4-bit.

## Timing
- Reset (reset_n=0 at an edge) forces these values, including mid-transfer:
  - outputs: usb_alen=usb_rdn=usb_wrn=usb_cen=1, usb_d_oe=0, usb_addr=0, usb_d_out=0, rd_data=0
  - handshakes: rd_valid=0, done=0, busy=0, cmd_ready=0, wr_ready=0
  - state: IDLE
- The aborted command produces no done. cmd_ready=1 from the first cycle after reset_n returns high.
- Per-byte cost:
  - read: SETUP_CYC+STROBE_CYC+HOLD_CYC cycles
  - write: that plus the FETCH cycles (at least 1)
- Command overhead: STROBE_CYC+HOLD_CYC (address phase) + 1 (END) + 1 (IDLE before the next accept). Back-to-back commands are therefore separated by at least one IDLE cycle with usb_cen=1.
- cmd_valid and wr_valid are ignored outside IDLE and FETCH respectively.

## Test plan
- Write, defaults, addr=0x2A, len=1, wr_data=0x5C ready (accept at cycle 0) ->
  - ALE low cycles 1-4, FETCH cycle 7
  - SETUP 8-9 with usb_d_out=0x5C and oe=1
  - usb_wrn low cycles 10-13
  - done at cycle 16, cmd_ready=1 at cycle 17
- Read, defaults, addr=0x03, len=3, responder returns 0x11/0x22/0x33 -> usb_rdn low 9-12, 17-20, 25-28; rd_valid at 13, 21 and 29 with those bytes; done at 31; oe=0 throughout.
- Write len=2 with wr_valid withheld 10 cycles before the second byte -> FETCH held 10 cycles with usb_cen=0 and usb_wrn=1; the second byte then completes normally.
- cmd_len=0 -> done one cycle after accept; usb_cen, usb_alen, usb_rdn and usb_wrn never go low.
- reset_n low during the 2nd STROBE cycle of a write -> next cycle all strobes high, oe=0, no done; a fresh read command afterwards completes correctly.
- Two commands with cmd_valid held high -> second accepted exactly 1 cycle after the first done; usb_cen high for at least 1 cycle between bursts.
